// File: rtl/multicycle_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_addsub_pkg
//  Description : Shared definitions for the multicycle add/subtract datapath:
//                opcode encodings, FSM state encodings and the slice-counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_addsub_pkg;

  // Opcodes. Bit 1 selects the accumulator as the left operand; bit 0
  // selects subtraction (invert right operand, carry-in of 1).
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_ACC    = 2'b10;
  localparam logic [1:0] OP_ACCSUB = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bits needed to count 0..n-1; never less than one so the counter always
  // exists, even when a single slice covers the whole word.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_addsub_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : slice_adder
//  Description : SLICE-bit ripple-carry adder built from full-adder cells.
//                Also exposes the carry into the slice MSB so the parent can
//                derive signed overflow on the final slice.
//  Ports       : x, y   - operand slices
//                cin    - carry into bit 0
//                sum    - slice sum
//                cout   - carry out of the slice MSB
//                c_msb  - carry into the slice MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
  end

  assign cout  = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/multicycle_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_addsub
//  Description : WIDTH-bit two's-complement add / subtract / accumulate unit
//                that reuses one SLICE-bit ripple adder over WIDTH/SLICE
//                cycles, LSB slice first, behind a start/busy/done handshake.
//  Ports       : CLOCK_50   - clock, rising edge
//                KEY0       - asynchronous active-low reset
//                start      - request, sampled only while idle
//                op         - 00 S=A+B, 01 S=A-B, 10 S=S+A, 11 S=S-A
//                A, B       - operands (B unused for accumulate ops)
//                clear      - synchronous clear of result/flags, aborts RUN
//                busy       - operation in progress
//                done       - one-cycle pulse, S/cout/overflow updated
//                S          - result register
//                cout       - carry out of MSB (subtract: 1 = no borrow)
//                overflow   - signed overflow of last operation
//                sticky_ovf - OR of overflow since last clear/reset
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_addsub
  import multicycle_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow,
  output logic             sticky_ovf
);

  localparam int              c_N    = WIDTH / SLICE;
  localparam int              c_CW   = cnt_width(c_N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  logic [0:0]       r_state;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_sticky;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_opx;
  logic [WIDTH-1:0] w_opy;
  logic [SLICE-1:0] w_sum;
  logic             w_co;
  logic             w_cmsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_work_next;

  // Operand selection at acceptance. Subtraction is x + ~y + 1, the +1
  // entering as the initial carry (op[0]).
  always_comb begin
    w_opx = A;
    w_opy = B;
    case (op)
      OP_ADD:    begin w_opx = A; w_opy = B;  end
      OP_SUB:    begin w_opx = A; w_opy = ~B; end
      OP_ACC:    begin w_opx = r_s; w_opy = A;  end
      OP_ACCSUB: begin w_opx = r_s; w_opy = ~A; end
      default:   begin w_opx = A; w_opy = B;  end
    endcase
  end

  // Operands are shifted right each cycle so the current slice always sits
  // in the low bits; no variable part-select is needed.
  slice_adder #(
    .SLICE (SLICE)
  ) u_slice_adder (
    .x     (r_x[SLICE-1:0]),
    .y     (r_y[SLICE-1:0]),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_co),
    .c_msb (w_cmsb)
  );

  // The working sum fills from the top: each new slice enters at the MSB end
  // and earlier slices move down, so after N cycles slice 0 is at bit 0.
  assign w_work_next = (r_work >> SLICE) | (WIDTH'(w_sum) << (WIDTH - SLICE));

  // Only meaningful on the last slice, where c_msb is the carry into bit
  // WIDTH-1 and w_co the carry out of it.
  assign w_ovf = w_cmsb ^ w_co;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (clear) begin
      // Clear wins over start and aborts any operation without a done pulse.
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x     <= w_opx;
            r_y     <= w_opy;
            r_carry <= op[0];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_x     <= r_x >> SLICE;
          r_y     <= r_y >> SLICE;
          r_carry <= w_co;
          r_work  <= w_work_next;
          r_cnt   <= r_cnt + c_CW'(1);
          if (r_cnt == c_LAST) begin
            r_s      <= w_work_next;
            r_cout   <= w_co;
            r_ovf    <= w_ovf;
            r_sticky <= r_sticky | w_ovf;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign S          = r_s;
  assign cout       = r_cout;
  assign overflow   = r_ovf;
  assign sticky_ovf = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_addsub
//  Description : Directed self-checking bench for multicycle_addsub. Drives a
//                16/4 instance through add/sub/accumulate, handshake, clear
//                and reset-abort cases, plus 8/1 and 8/8 instances for
//                latency extremes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_addsub;

  logic        clk;
  logic        KEY0;
  logic        clear;

  // 16-bit, 4-bit slice instance
  logic        start;
  logic [1:0]  op;
  logic [15:0] A, B;
  logic        busy, done, cout, overflow, sticky_ovf;
  logic [15:0] S;

  // 8-bit, 1-bit slice instance
  logic        a_start;
  logic [7:0]  a_A, a_B;
  logic        a_busy, a_done, a_cout, a_ovf, a_sticky;
  logic [7:0]  a_S;

  // 8-bit, 8-bit slice instance
  logic        b_start;
  logic [7:0]  b_A, b_B;
  logic        b_busy, b_done, b_cout, b_ovf, b_sticky;
  logic [7:0]  b_S;

  int n_vec;
  int n_err;
  int lat;
  int seen;

  multicycle_addsub #(.WIDTH(16), .SLICE(4)) dut (
    .CLOCK_50(clk), .KEY0(KEY0), .start(start), .op(op), .A(A), .B(B),
    .clear(clear), .busy(busy), .done(done), .S(S), .cout(cout),
    .overflow(overflow), .sticky_ovf(sticky_ovf)
  );

  multicycle_addsub #(.WIDTH(8), .SLICE(1)) dut_s1 (
    .CLOCK_50(clk), .KEY0(KEY0), .start(a_start), .op(2'b00), .A(a_A), .B(a_B),
    .clear(clear), .busy(a_busy), .done(a_done), .S(a_S), .cout(a_cout),
    .overflow(a_ovf), .sticky_ovf(a_sticky)
  );

  multicycle_addsub #(.WIDTH(8), .SLICE(8)) dut_s8 (
    .CLOCK_50(clk), .KEY0(KEY0), .start(b_start), .op(2'b00), .A(b_A), .B(b_B),
    .clear(clear), .busy(b_busy), .done(b_done), .S(b_S), .cout(b_cout),
    .overflow(b_ovf), .sticky_ovf(b_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge (the acceptance edge).
  task automatic accept(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
  endtask

  // Cycles from now until done is seen, bounded.
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] s_e,
                              input logic c_e, input logic o_e, input logic st_e);
    check({tag, ".S"},      32'(S),          32'(s_e));
    check({tag, ".cout"},   32'(cout),       32'(c_e));
    check({tag, ".ovf"},    32'(overflow),   32'(o_e));
    check({tag, ".sticky"}, 32'(sticky_ovf), 32'(st_e));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    KEY0 = 1'b0; clear = 1'b0;
    start = 1'b0; op = 2'b00; A = '0; B = '0;
    a_start = 1'b0; a_A = '0; a_B = '0;
    b_start = 1'b0; b_A = '0; b_B = '0;
    tick(); tick();

    // Reset state
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));
    check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    KEY0 = 1'b1;
    tick();

    // 1: signed overflow on add, latency 4
    accept(2'b00, 16'h7FFF, 16'h0001);
    check("t1.busy_after_accept", 32'(busy), 32'(1));
    check("t1.S_held_in_run", 32'(S), 32'(16'h0000));
    wait_done(lat);
    check("t1.latency", 32'(lat), 32'(4));
    check("t1.busy_at_done", 32'(busy), 32'(0));
    check_result("t1", 16'h8000, 1'b0, 1'b1, 1'b1);
    tick();
    check("t1.done_one_cycle", 32'(done), 32'(0));

    // 2: subtract with borrow, then subtract with overflow
    accept(2'b01, 16'h0003, 16'h0005);
    wait_done(lat);
    check_result("t2a", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    accept(2'b01, 16'h8000, 16'h0001);
    wait_done(lat);
    check_result("t2b", 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // 3: clear, accumulate three times, accumulate-subtract, clear
    clear = 1'b1; tick(); clear = 1'b0;
    check_result("t3.clr", 16'h0000, 1'b0, 1'b0, 1'b0);
    accept(2'b10, 16'h4000, 16'h0000);
    wait_done(lat);
    check_result("t3.acc1", 16'h4000, 1'b0, 1'b0, 1'b0);
    accept(2'b10, 16'h4000, 16'h0000);
    wait_done(lat);
    check_result("t3.acc2", 16'h8000, 1'b0, 1'b1, 1'b1);
    accept(2'b10, 16'h4000, 16'h0000);
    wait_done(lat);
    check_result("t3.acc3", 16'hC000, 1'b0, 1'b0, 1'b1);
    accept(2'b11, 16'h4000, 16'h0000);
    wait_done(lat);
    check_result("t3.accsub", 16'h8000, 1'b1, 1'b0, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_result("t3.clr2", 16'h0000, 1'b0, 1'b0, 1'b0);

    // 4: start during RUN ignored; back-to-back start on done cycle
    accept(2'b00, 16'h1234, 16'h1111);
    start = 1'b1; A = 16'h5555;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("t4.latency", 32'(lat + 1), 32'(4));
    check_result("t4", 16'h2345, 1'b0, 1'b0, 1'b0);
    accept(2'b00, 16'h0100, 16'h0001);
    check("t4.b2b.done_dropped", 32'(done), 32'(0));
    check("t4.b2b.busy", 32'(busy), 32'(1));
    check("t4.b2b.S_held", 32'(S), 32'(16'h2345));
    wait_done(lat);
    check("t4.b2b.latency", 32'(lat), 32'(4));
    check_result("t4.b2b", 16'h0101, 1'b0, 1'b0, 1'b0);

    // 5a: reset after two slices aborts immediately
    accept(2'b00, 16'h0F0F, 16'h0101);
    tick(); tick();
    KEY0 = 1'b0;
    #1;
    check("t5.rst.busy", 32'(busy), 32'(0));
    check("t5.rst.S", 32'(S), 32'(16'h0000));
    tick();
    KEY0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen++;
    end
    check("t5.rst.no_done", 32'(seen), 32'(0));

    // 5b: clear in RUN aborts and zeroes the result
    accept(2'b00, 16'h0011, 16'h0022);
    wait_done(lat);
    check_result("t5.pre", 16'h0033, 1'b0, 1'b0, 1'b0);
    accept(2'b00, 16'h0001, 16'h0001);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t5.clr.busy", 32'(busy), 32'(0));
    check("t5.clr.S", 32'(S), 32'(16'h0000));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen++;
    end
    check("t5.clr.no_done", 32'(seen), 32'(0));

    // 6a: WIDTH=8 SLICE=1, latency 8
    a_start = 1'b1; a_A = 8'hFF; a_B = 8'h01;
    tick();
    a_start = 1'b0;
    lat = 0;
    while (!a_done && lat < 40) begin tick(); lat++; end
    check("t6a.latency", 32'(lat), 32'(8));
    check("t6a.S", 32'(a_S), 32'(8'h00));
    check("t6a.cout", 32'(a_cout), 32'(1));
    check("t6a.ovf", 32'(a_ovf), 32'(0));

    // 6b: WIDTH=8 SLICE=8, latency 1
    b_start = 1'b1; b_A = 8'hFF; b_B = 8'h01;
    tick();
    b_start = 1'b0;
    lat = 0;
    while (!b_done && lat < 40) begin tick(); lat++; end
    check("t6b.latency", 32'(lat), 32'(1));
    check("t6b.S", 32'(b_S), 32'(8'h00));
    check("t6b.cout", 32'(b_cout), 32'(1));
    check("t6b.ovf", 32'(b_ovf), 32'(0));
    b_start = 1'b1; b_A = 8'h7F; b_B = 8'h01;
    tick();
    b_start = 1'b0;
    lat = 0;
    while (!b_done && lat < 40) begin tick(); lat++; end
    check("t6c.S", 32'(b_S), 32'(8'h80));
    check("t6c.ovf", 32'(b_ovf), 32'(1));
    check("t6c.sticky", 32'(b_sticky), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
